// File: rtl/bht_pkg.sv
// rtl/bht_pkg.sv - shared helpers for the set-associative branch history table
package bht_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Weakly-taken value; new entries start here and misses report one below it.
  function automatic int cnt_mid(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int cnt_sat_inc(input int v, input int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  function automatic int cnt_sat_dec(input int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/bht_assoc_if.sv
// rtl/bht_assoc_if.sv - fetch lookup and execute update bundle for bht_assoc
interface bht_assoc_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 2
);
  logic              flush;
  logic [ADDR_W-1:0] pc_4;
  logic              guess_hit;
  logic              guess_taken;
  logic [ADDR_W-1:0] guess_new_pc;
  logic [CNT_W-1:0]  guess_state;
  logic              update_en;
  logic [ADDR_W-1:0] update_pc_4;
  logic [ADDR_W-1:0] update_pc_remote;
  logic [CNT_W-1:0]  update_state_old;
  logic              branch_succ;

  modport master (
    output flush, pc_4, update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
    input  guess_hit, guess_taken, guess_new_pc, guess_state
  );

  modport slave (
    input  flush, pc_4, update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
    output guess_hit, guess_taken, guess_new_pc, guess_state
  );
endinterface

// File: rtl/bht_lru.sv
// rtl/bht_lru.sv - true-LRU age tracking per set; age 0 is MRU, age WAYS-1 is the victim
module bht_lru
  import bht_pkg::*;
#(
  parameter int SETS = 4,
  parameter int WAYS = 2,
  localparam int IDX_W = clog2(SETS),
  localparam int WAY_W = clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim [SETS]
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] age_d [SETS][WAYS];

  always_comb begin
    age_d = age_q;
    if (clr) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_d[s][w] = WAY_W'(w);
    end else if (touch_en) begin
      // Everything younger than the touched way ages by one; the rest keep their rank.
      for (int w = 0; w < WAYS; w++)
        if (age_q[touch_set][w] < age_q[touch_set][touch_way])
          age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
      age_d[touch_set][touch_way] = '0;
    end
  end

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      victim[s] = '0;
      for (int w = 0; w < WAYS; w++)
        if (age_q[s][w] == WAY_W'(WAYS - 1)) victim[s] = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/bht_assoc.sv
// rtl/bht_assoc.sv - set-associative branch history/target table with true-LRU replacement
// Optional BHT_FWD_EN: same-cycle update of the looked-up key is forwarded to the lookup outputs.
module bht_assoc
  import bht_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 2,
  localparam int IDX_W = clog2(SETS),
  localparam int WAY_W = clog2(WAYS),
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input logic       clk,
  input logic       rst,
  bht_assoc_if.slave bus
);

  localparam logic [CNT_W-1:0] MID = CNT_W'(cnt_mid(CNT_W));

  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_d   [SETS][WAYS];
  logic [CNT_W-1:0]  cnt_q   [SETS][WAYS];
  logic [CNT_W-1:0]  cnt_d   [SETS][WAYS];

  logic [IDX_W-1:0]  l_set, u_set;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              l_hit, u_hit;
  logic [WAY_W-1:0]  l_way, u_way, a_way;
  logic [CNT_W-1:0]  new_cnt;
  logic              touch_en;
  logic [WAY_W-1:0]  touch_way;
  logic [WAY_W-1:0]  victim [SETS];
  logic              hit;
  logic [CNT_W-1:0]  state;
  logic [ADDR_W-1:0] tgt;

  assign l_set = bus.pc_4[IDX_W-1:0];
  assign l_tag = bus.pc_4[ADDR_W-1:IDX_W];
  assign u_set = bus.update_pc_4[IDX_W-1:0];
  assign u_tag = bus.update_pc_4[ADDR_W-1:IDX_W];

  // Descending scans so the lowest-index match or free way is the one that sticks.
  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    u_hit = 1'b0;
    u_way = '0;
    a_way = victim[u_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[l_set][w] && tag_q[l_set][w] == l_tag) begin
        l_hit = 1'b1;
        l_way = WAY_W'(w);
      end
      if (valid_q[u_set][w] && tag_q[u_set][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid_q[u_set][w]) a_way = WAY_W'(w);
    end
  end

  assign new_cnt = bus.branch_succ
                 ? CNT_W'(cnt_sat_inc(int'(bus.update_state_old), CNT_W))
                 : CNT_W'(cnt_sat_dec(int'(bus.update_state_old)));

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    touch_en  = 1'b0;
    touch_way = '0;
    if (bus.flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_d[s][w] = 1'b0;
    end else if (bus.update_en) begin
      if (u_hit) begin
        cnt_d[u_set][u_way] = new_cnt;
        if (bus.branch_succ) tgt_d[u_set][u_way] = bus.update_pc_remote;
        touch_en  = 1'b1;
        touch_way = u_way;
      end else if (bus.branch_succ) begin
        valid_d[u_set][a_way] = 1'b1;
        tag_d[u_set][a_way]   = u_tag;
        tgt_d[u_set][a_way]   = bus.update_pc_remote;
        cnt_d[u_set][a_way]   = MID;
        touch_en  = 1'b1;
        touch_way = a_way;
      end
    end
  end

  always_comb begin
    hit   = l_hit;
    state = l_hit ? cnt_q[l_set][l_way] : MID - 1'b1;
    tgt   = tgt_q[l_set][l_way];
`ifdef BHT_FWD_EN
    if (bus.update_en && !bus.flush && bus.update_pc_4 == bus.pc_4) begin
      hit = l_hit | bus.branch_succ;
      if (u_hit)                state = new_cnt;
      else if (bus.branch_succ) state = MID;
      if (bus.branch_succ)      tgt   = bus.update_pc_remote;
    end
`endif
  end

  assign bus.guess_hit    = hit;
  assign bus.guess_state  = state;
  assign bus.guess_taken  = hit & state[CNT_W-1];
  assign bus.guess_new_pc = bus.guess_taken ? tgt : bus.pc_4;

  bht_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.flush),
    .touch_en  (touch_en),
    .touch_set (u_set),
    .touch_way (touch_way),
    .victim    (victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          valid_q[s][w] <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_bht_assoc.sv
// tb/tb_bht_assoc.sv - directed plus randomized bench for bht_assoc against a recency-list model
module tb_bht_assoc;
  localparam int ADDR_W = 10;
  localparam int SETS   = 4;
  localparam int WAYS   = 2;
  localparam int CNT_W  = 2;
  localparam int MIDV   = 2;
  localparam int MAXC   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bht_assoc_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  bht_assoc #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_tgt   [SETS][WAYS];
  int m_cnt   [SETS][WAYS];
  int m_lru   [SETS][$];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_lru[s].push_back(w);
      end
    end
  endtask

  task automatic model_touch(input int s, input int w);
    for (int i = 0; i < m_lru[s].size(); i++)
      if (m_lru[s][i] == w) begin
        m_lru[s].delete(i);
        break;
      end
    m_lru[s].push_front(w);
  endtask

  function automatic int model_find(input int key);
    int s = key % SETS;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == key / SETS) return w;
    return -1;
  endfunction

  function automatic int next_cnt(input int old, input bit succ);
    if (succ) return (old < MAXC) ? old + 1 : MAXC;
    return (old > 0) ? old - 1 : 0;
  endfunction

  task automatic model_update();
    int key, s, w;
    if (bus.flush) begin
      model_reset();
    end else if (bus.update_en) begin
      key = int'(bus.update_pc_4);
      s = key % SETS;
      w = model_find(key);
      if (w >= 0) begin
        m_cnt[s][w] = next_cnt(int'(bus.update_state_old), bus.branch_succ);
        if (bus.branch_succ) m_tgt[s][w] = int'(bus.update_pc_remote);
        model_touch(s, w);
      end else if (bus.branch_succ) begin
        w = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
        if (w < 0) w = m_lru[s][$];
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = key / SETS;
        m_tgt[s][w]   = int'(bus.update_pc_remote);
        m_cnt[s][w]   = MIDV;
        model_touch(s, w);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_lookup(input string name);
    int pc, w, h, st, tgt, t, npc;
    pc  = int'(bus.pc_4);
    w   = model_find(pc);
    h   = (w >= 0) ? 1 : 0;
    st  = h ? m_cnt[pc % SETS][w] : MIDV - 1;
    tgt = h ? m_tgt[pc % SETS][w] : 0;
`ifdef BHT_FWD_EN
    if (bus.update_en && !bus.flush && bus.update_pc_4 == bus.pc_4) begin
      if (h) st = next_cnt(int'(bus.update_state_old), bus.branch_succ);
      else if (bus.branch_succ) st = MIDV;
      if (bus.branch_succ) begin
        tgt = int'(bus.update_pc_remote);
        h = 1;
      end
    end
`endif
    t   = (h != 0 && st >= MIDV) ? 1 : 0;
    npc = t ? tgt : pc;
    check({name, ".hit"},    32'(bus.guess_hit),    32'(h));
    check({name, ".taken"},  32'(bus.guess_taken),  32'(t));
    check({name, ".new_pc"}, 32'(bus.guess_new_pc), 32'(npc));
    check({name, ".state"},  32'(bus.guess_state),  32'(st));
  endtask

  task automatic drive(input int pc, input bit en, input int upc, input int rem,
                       input int old, input bit succ, input bit fl);
    bus.pc_4             = ADDR_W'(pc);
    bus.update_en        = en;
    bus.update_pc_4      = ADDR_W'(upc);
    bus.update_pc_remote = ADDR_W'(rem);
    bus.update_state_old = CNT_W'(old);
    bus.branch_succ      = succ;
    bus.flush            = fl;
  endtask

  task automatic step(input string name, input int pc, input bit en, input int upc,
                      input int rem, input int old, input bit succ, input bit fl);
    drive(pc, en, upc, rem, old, succ, fl);
    @(negedge clk);
    check_lookup(name);
  endtask

  task automatic edge_();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic upd(input string name, input int key, input int rem, input int old, input bit succ);
    step(name, key, 1'b1, key, rem, old, succ, 1'b0);
    edge_();
  endtask

  task automatic look(input string name, input int pc);
    step(name, pc, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    drive(1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look("t1", 1);
    check("t1_hit", 32'(bus.guess_hit), 32'd0);
    check("t1_new_pc", 32'(bus.guess_new_pc), 32'd1);
    check("t1_state", 32'(bus.guess_state), 32'd1);
    edge_();

    upd("t2_alloc", 1, 'h10, 2, 1'b1);
    look("t2_look", 1);
    check("t2_taken", 32'(bus.guess_taken), 32'd1);
    check("t2_new_pc", 32'(bus.guess_new_pc), 32'h10);
    check("t2_state_mid", 32'(bus.guess_state), 32'd2);
    edge_();
    upd("t2_inc", 1, 'h10, 2, 1'b1);
    look("t2_look2", 1);
    check("t2_state_inc", 32'(bus.guess_state), 32'd3);
    edge_();

    upd("t3_a5", 5, 'h50, 0, 1'b1);
    upd("t3_a9", 9, 'h90, 0, 1'b1);
    look("t3_l1", 1);
    check("t3_1_evicted", 32'(bus.guess_hit), 32'd0);
    edge_();
    look("t3_l5", 5);
    check("t3_5_pc", 32'(bus.guess_new_pc), 32'h50);
    edge_();
    look("t3_l9", 9);
    check("t3_9_pc", 32'(bus.guess_new_pc), 32'h90);
    edge_();
    upd("t3_r5", 5, 'h50, 2, 1'b1);
    upd("t3_aD", 'hD, 'hD0, 0, 1'b1);
    look("t3_l9b", 9);
    check("t3_9_evicted", 32'(bus.guess_hit), 32'd0);
    edge_();
    look("t3_l5b", 5);
    check("t3_5_kept", 32'(bus.guess_hit), 32'd1);
    edge_();

    upd("t4_sat", 5, 'h50, 3, 1'b1);
    look("t4_l5", 5);
    check("t4_sat_state", 32'(bus.guess_state), 32'd3);
    edge_();
    upd("t4_dec", 5, 'h55, 1, 1'b0);
    look("t4_l5b", 5);
    check("t4_dec_state", 32'(bus.guess_state), 32'd0);
    check("t4_dec_taken", 32'(bus.guess_taken), 32'd0);
    check("t4_dec_pc", 32'(bus.guess_new_pc), 32'd5);
    edge_();
    upd("t4_noalloc", 2, 'h20, 3, 1'b0);
    look("t4_l2", 2);
    check("t4_noalloc_hit", 32'(bus.guess_hit), 32'd0);
    edge_();

    step("t5_flush", 3, 1'b1, 3, 'h30, 2, 1'b1, 1'b1);
    edge_();
    look("t5_l3", 3);
    check("t5_l3_hit", 32'(bus.guess_hit), 32'd0);
    edge_();
    look("t5_l5", 5);
    check("t5_l5_hit", 32'(bus.guess_hit), 32'd0);
    edge_();
    step("t5_rstupd", 7, 1'b1, 7, 'h70, 2, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    look("t5_l7", 7);
    check("t5_rst_lost", 32'(bus.guess_hit), 32'd0);
    edge_();

    step("t6_fwd", 3, 1'b1, 3, 'h30, 1, 1'b1, 1'b0);
`ifdef BHT_FWD_EN
    check("t6_same_hit", 32'(bus.guess_hit), 32'd1);
    check("t6_same_pc", 32'(bus.guess_new_pc), 32'h30);
`else
    check("t6_same_hit", 32'(bus.guess_hit), 32'd0);
`endif
    edge_();
    look("t6_next", 3);
    check("t6_next_hit", 32'(bus.guess_hit), 32'd1);
    check("t6_next_pc", 32'(bus.guess_new_pc), 32'h30);
    edge_();

    for (int i = 0; i < 400; i++) begin
      int pc, upc;
      pc  = int'($urandom_range(0, 23));
      upc = ($urandom_range(0, 3) == 0) ? pc : int'($urandom_range(0, 23));
      step("rand", pc, 1'($urandom_range(0, 1)), upc, int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      edge_();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
